// File: rtl/decompressor_pkg.sv
// Shared types and job field widths for the decompressor job scheduler and its lane pickers.
package decompressor_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2
  } sched_state_e;

  localparam int JOB_ID_W = 16;
  localparam int ADDR_W   = 64;
  localparam int LEN_MSB  = 31;
  localparam int LEN_LSB  = 6;
endpackage

// File: rtl/lane_grant_picker.sv
// Combinational lane picker: free vector (+ pointer) to one-hot grant and index.
// Round-robin from the pointer when DEC_SCHED_ROUND_ROBIN_EN is defined, else lowest-index first.
module lane_grant_picker #(
  parameter int N   = 3,
  parameter int LOG = 2
) (
  input  logic [N-1:0]   free,
  input  logic [LOG-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [LOG-1:0] idx,
  output logic           any
);
`ifdef DEC_SCHED_ROUND_ROBIN_EN
  logic [LOG-1:0] lane;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    lane   = '0;
    // walk upward from the pointer, wrapping modulo N
    for (int k = 0; k < N; k++) begin
      lane = LOG'((int'(ptr) + k) % N);
      if (!any && free[lane]) begin
        any          = 1'b1;
        onehot[lane] = 1'b1;
        idx          = lane;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && free[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = LOG'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/decompressor_job_scheduler.sv
// Accepts decompression jobs and broadcasts each to one free lane via a one-hot select.
// DEC_SCHED_ROUND_ROBIN_EN selects round-robin lane choice; otherwise fixed priority.
module decompressor_job_scheduler
  import decompressor_pkg::*;
#(
  parameter int NUM_DECOMPRESSOR     = 3,
  parameter int NUM_DECOMPRESSOR_LOG = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_req_valid,
  output logic                            job_req_ready,
  input  logic [JOB_ID_W-1:0]             job_id_in,
  input  logic [ADDR_W-1:0]               des_address_in,
  input  logic [LEN_MSB:LEN_LSB]          decompression_length_in,
  output logic                            job_valid,
  output logic [JOB_ID_W-1:0]             job_id_out,
  output logic [ADDR_W-1:0]               des_address_out,
  output logic [LEN_MSB:LEN_LSB]          decompression_length_out,
  output logic [NUM_DECOMPRESSOR-1:0]     dec_select_idle,
  input  logic [NUM_DECOMPRESSOR-1:0]     dec_done,
  output logic [NUM_DECOMPRESSOR-1:0]     busy_vec,
  output logic [NUM_DECOMPRESSOR_LOG:0]   busy_count,
  output logic                            sched_error
);
  localparam int N   = NUM_DECOMPRESSOR;
  localparam int LOG = NUM_DECOMPRESSOR_LOG;

  sched_state_e           state;
  logic [JOB_ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LEN_MSB:LEN_LSB] len_q;
  logic [N-1:0]           pick_oh;
  logic [LOG-1:0]         pick_idx;
  logic                   pick_any;
  logic [LOG-1:0]         pick_ptr;
  logic [N-1:0]           issue_set;

`ifdef DEC_SCHED_ROUND_ROBIN_EN
  logic [LOG-1:0] ptr;
  logic [LOG-1:0] grant_idx_q;
  assign pick_ptr = ptr;
`else
  logic unused_idx;
  assign unused_idx = ^pick_idx;
  assign pick_ptr   = '0;
`endif

  lane_grant_picker #(.N(N), .LOG(LOG)) u_picker (
    .free   (~busy_vec),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign job_id_out               = id_q;
  assign des_address_out          = addr_q;
  assign decompression_length_out = len_q;

  // select is only non-zero during ISSUE, so it doubles as the busy-set vector
  assign issue_set = dec_select_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      job_req_ready   <= 1'b1;
      job_valid       <= 1'b0;
      dec_select_idle <= '0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
`ifdef DEC_SCHED_ROUND_ROBIN_EN
      ptr             <= '0;
      grant_idx_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (job_req_valid && job_req_ready) begin
            id_q          <= job_id_in;
            addr_q        <= des_address_in;
            len_q         <= decompression_length_in;
            job_req_ready <= 1'b0;
            state         <= SELECT;
          end
        end
        SELECT: begin
          if (pick_any) begin
            dec_select_idle <= pick_oh;
            job_valid       <= 1'b1;
`ifdef DEC_SCHED_ROUND_ROBIN_EN
            grant_idx_q     <= pick_idx;
`endif
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          job_valid       <= 1'b0;
          dec_select_idle <= '0;
          job_req_ready   <= 1'b1;
          state           <= IDLE;
`ifdef DEC_SCHED_ROUND_ROBIN_EN
          ptr <= (grant_idx_q == LOG'(N - 1)) ? '0 : grant_idx_q + 1'b1;
`endif
        end
        default: begin
          job_valid       <= 1'b0;
          dec_select_idle <= '0;
          job_req_ready   <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec    <= '0;
      sched_error <= 1'b0;
    end else begin
      busy_vec <= (busy_vec & ~dec_done) | issue_set;
      // done on an idle lane, or done colliding with an issue, is a protocol violation
      if (|(dec_done & ~busy_vec) || |(dec_done & issue_set))
        sched_error <= 1'b1;
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < N; i++)
      busy_count = busy_count + (LOG + 1)'(busy_vec[i]);
  end
endmodule

// File: tb/tb_decompressor_job_scheduler.sv
// Self-checking bench for decompressor_job_scheduler: directed scenarios plus random traffic vs a transaction-level model.
module tb_decompressor_job_scheduler;
  localparam int N   = 3;
  localparam int LOG = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_req_valid;
  logic          job_req_ready;
  logic [15:0]   job_id_in;
  logic [63:0]   des_address_in;
  logic [31:6]   decompression_length_in;
  logic          job_valid;
  logic [15:0]   job_id_out;
  logic [63:0]   des_address_out;
  logic [31:6]   decompression_length_out;
  logic [N-1:0]  dec_select_idle;
  logic [N-1:0]  dec_done;
  logic [N-1:0]  busy_vec;
  logic [LOG:0]  busy_count;
  logic          sched_error;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: set of busy lanes, next-search pointer, sticky error
  bit [N-1:0] m_busy;
  int         m_ptr;
  bit         m_err;

  decompressor_job_scheduler #(.NUM_DECOMPRESSOR(N), .NUM_DECOMPRESSOR_LOG(LOG)) dut (
    .clk(clk), .rst(rst), .job_req_valid(job_req_valid), .job_req_ready(job_req_ready),
    .job_id_in(job_id_in), .des_address_in(des_address_in),
    .decompression_length_in(decompression_length_in), .job_valid(job_valid),
    .job_id_out(job_id_out), .des_address_out(des_address_out),
    .decompression_length_out(decompression_length_out), .dec_select_idle(dec_select_idle),
    .dec_done(dec_done), .busy_vec(busy_vec), .busy_count(busy_count), .sched_error(sched_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int predict_lane();
    int start;
`ifdef DEC_SCHED_ROUND_ROBIN_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++)
      if (!m_busy[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    job_req_valid = 1'b0;
    dec_done = '0;
    tick();
    tick();
    rst = 1'b0;
    m_busy = '0;
    m_ptr  = 0;
    m_err  = 1'b0;
  endtask

  // exp_lane >= 0 pins the expected lane to a constant; -1 takes it from the model
  task automatic run_job(input logic [15:0] id, input logic [63:0] a, input logic [31:6] l, input int exp_lane);
    int w = 0;
    int lane;
    logic [N-1:0] oh;
    while (!job_req_ready && w < 50) begin tick(); w++; end
    n_checks++;
    if (w == 50) begin
      n_fail++;
      $display("FAIL accept_wait: job_req_ready=%b after 50 cycles, required 1", job_req_ready);
      return;
    end
    job_req_valid = 1'b1;
    job_id_in = id; des_address_in = a; decompression_length_in = l;
    tick();
    job_req_valid = 1'b0;
    job_id_in = 16'($urandom); des_address_in = {$urandom, $urandom};
    decompression_length_in = 26'($urandom);
    lane = (exp_lane >= 0) ? exp_lane : predict_lane();
    oh = '0;
    oh[lane] = 1'b1;
    n_checks++;
    if (job_valid !== 1'b0 || job_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL select_cycle: job_valid=%b ready=%b, required 0/0", job_valid, job_req_ready);
    end
    tick();
    n_checks++;
    if (job_valid !== 1'b1 || dec_select_idle !== oh) begin
      n_fail++;
      $display("FAIL issue: job_valid=%b sel=%b, required 1/%b", job_valid, dec_select_idle, oh);
    end
    n_checks++;
    if (job_id_out !== id || des_address_out !== a || decompression_length_out !== l) begin
      n_fail++;
      $display("FAIL issue_fields: id=%h addr=%h len=%h, required %h/%h/%h",
               job_id_out, des_address_out, decompression_length_out, id, a, l);
    end
    m_busy[lane] = 1'b1;
    m_ptr = (lane + 1) % N;
    tick();
    n_checks++;
    if (job_valid !== 1'b0 || dec_select_idle !== '0 || busy_vec !== m_busy ||
        int'(busy_count) != model_count() || job_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_issue: valid=%b sel=%b busy=%b cnt=%0d ready=%b, required 0/0/%b/%0d/1",
               job_valid, dec_select_idle, busy_vec, busy_count, job_req_ready, m_busy, model_count());
    end
  endtask

  task automatic pulse_done(input logic [N-1:0] mask);
    dec_done = mask;
    tick();
    dec_done = '0;
    if ((mask & ~m_busy) != '0) m_err = 1'b1;
    m_busy = m_busy & ~mask;
    n_checks++;
    if (busy_vec !== m_busy || sched_error !== m_err || int'(busy_count) != model_count()) begin
      n_fail++;
      $display("FAIL done: busy=%b err=%b cnt=%0d, required %b/%b/%0d",
               busy_vec, sched_error, busy_count, m_busy, m_err, model_count());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (job_req_ready !== 1'b1 || job_valid !== 1'b0 || dec_select_idle !== '0 ||
        busy_vec !== '0 || busy_count !== '0 || sched_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b sel=%b busy=%b cnt=%0d err=%b",
               job_req_ready, job_valid, dec_select_idle, busy_vec, busy_count, sched_error);
    end
    n_checks++;
    if (job_id_out !== '0 || des_address_out !== '0 || decompression_length_out !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: id=%h addr=%h len=%h, required 0", job_id_out, des_address_out,
               decompression_length_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    run_job(16'h0005, 64'h1000, 26'h40, 0);
    n_checks++;
    if (busy_vec !== 3'b001 || busy_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_busy: busy=%b cnt=%0d, required 001/1", busy_vec, busy_count);
    end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    run_job(16'h0101, 64'hA000, 26'h10, 0);
    run_job(16'h0102, 64'hB000, 26'h20, 1);
    run_job(16'h0103, 64'hC000, 26'h30, 2);
    job_req_valid = 1'b1;
    job_id_in = 16'h0104; des_address_in = 64'hD000; decompression_length_in = 26'h44;
    tick();
    job_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (job_valid !== 1'b0 || job_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall: cycle %0d valid=%b ready=%b, required 0/0", i, job_valid, job_req_ready);
      end
      tick();
    end
    dec_done = 3'b010;
    tick();
    dec_done = '0;
    m_busy[1] = 1'b0;
    n_checks++;
    if (job_valid !== 1'b0 || busy_vec !== 3'b101) begin
      n_fail++;
      $display("FAIL release_select: valid=%b busy=%b, required 0/101", job_valid, busy_vec);
    end
    tick();
    n_checks++;
    if (job_valid !== 1'b1 || dec_select_idle !== 3'b010 || job_id_out !== 16'h0104) begin
      n_fail++;
      $display("FAIL release_issue: valid=%b sel=%b id=%h, required 1/010/0104",
               job_valid, dec_select_idle, job_id_out);
    end
    m_busy[1] = 1'b1;
    m_ptr = 2;
    tick();
    n_checks++;
    if (busy_vec !== 3'b111 || busy_count !== 3'd3 || sched_error !== 1'b0) begin
      n_fail++;
      $display("FAIL release_busy: busy=%b cnt=%0d err=%b, required 111/3/0", busy_vec, busy_count, sched_error);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_job(16'h0201, 64'h10, 26'h1, 0);
    run_job(16'h0202, 64'h20, 26'h2, 1);
    pulse_done(3'b001);
`ifdef DEC_SCHED_ROUND_ROBIN_EN
    run_job(16'h0203, 64'h30, 26'h3, 2);
    run_job(16'h0204, 64'h40, 26'h4, 0);
`else
    run_job(16'h0203, 64'h30, 26'h3, 0);
    run_job(16'h0204, 64'h40, 26'h4, 2);
`endif
  endtask

  task automatic test_idle_done_error();
    do_reset();
    pulse_done(3'b001);
    run_job(16'h0301, 64'h300, 26'h5, 0);
    tick();
    tick();
    n_checks++;
    if (sched_error !== 1'b1 || busy_vec !== 3'b001) begin
      n_fail++;
      $display("FAIL error_sticky: err=%b busy=%b, required 1/001", sched_error, busy_vec);
    end
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    run_job(16'h0401, 64'h400, 26'h6, 0);
    run_job(16'h0402, 64'h500, 26'h7, 1);
    job_req_valid = 1'b1;
    job_id_in = 16'h0403;
    tick();
    job_req_valid = 1'b0;
    tick();
    n_checks++;
    if (job_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_issue: valid=%b, required 1", job_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = '0; m_ptr = 0; m_err = 1'b0;
    n_checks++;
    if (job_valid !== 1'b0 || busy_vec !== '0 || busy_count !== '0) begin
      n_fail++;
      $display("FAIL reset_issue: valid=%b busy=%b cnt=%0d, required 0/000/0", job_valid, busy_vec, busy_count);
    end
    tick();
    n_checks++;
    if (job_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b, required 1", job_req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (job_valid !== 1'b0 || dec_select_idle !== '0) begin
        n_fail++;
        $display("FAIL reset_quiet: cycle %0d valid=%b sel=%b, required 0/0", i, job_valid, dec_select_idle);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0 && predict_lane() >= 0)
        run_job(16'($urandom), {$urandom, $urandom}, 26'($urandom), -1);
      else if (m_busy != '0)
        pulse_done(m_busy & N'($urandom | 1));
      else
        tick();
    end
    n_checks++;
    if (sched_error !== 1'b0 || busy_vec !== m_busy) begin
      n_fail++;
      $display("FAIL random_final: err=%b busy=%b, required 0/%b", sched_error, busy_vec, m_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    job_req_valid = 1'b0;
    job_id_in = '0; des_address_in = '0; decompression_length_in = '0;
    dec_done = '0;
    m_busy = '0; m_ptr = 0; m_err = 1'b0;
    test_reset();
    test_single();
    test_back_to_back_stall();
    test_wrap();
    test_idle_done_error();
    test_reset_in_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
